demux32_sipo: RTL and testbench

Serial-to-parallel capture block, the receive-side counterpart of the 32:1 bit multiplexer. The 32:1 mux emits word bit `i[s]` while `s` steps 0..31. This block demultiplexes that bit stream back into a 32-bit word: each accepted bit is steered into register position `idx`, the index counter is advanced, and the assembled word is presented on a valid/ready output. It sits directly downstream of the mux-based serializer in the lab datapath.

---
 rtl/demux32_pkg.sv | 14 +
 rtl/demux32_sipo_bit_index_counter.sv | 32 +++
 rtl/demux32_sipo.sv | 78 +++++++
 tb/tb_demux32_sipo.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux32_pkg.sv
// Shared constants and types for the serial-to-parallel capture block.
//   W        : word width (power of 2)
//   IW       : index width, log2(W)
//   IDX_LAST : last bit position of a word
//   word_t   : assembled word type
package demux32_pkg;

  localparam int unsigned W        = 32;
  localparam int unsigned IW       = 5;
  localparam int unsigned IDX_LAST = W - 1;

  typedef logic [W-1:0] word_t;

endpackage

// File: rtl/demux32_sipo_bit_index_counter.sv
// Bit position counter for the serial-to-parallel capture block.
//   clk, rst : clock, synchronous active-high reset
//   clr      : frame-align, forces the index back to 0
//   inc      : a bit was accepted this cycle, advance the index
//   idx      : position the next accepted bit is written to
//   wrap     : the accepted bit is the last one of the word
module bit_index_counter import demux32_pkg::*; #(
  parameter int unsigned   IW   = demux32_pkg::IW,
  parameter logic [IW-1:0] LAST = IW'(IDX_LAST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          wrap
);

  assign wrap = inc && (idx == LAST);

  // W is a power of 2, so the natural overflow of idx is the modulo-W wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/demux32_sipo.sv
// Serial-to-parallel capture: demultiplexes an LSB-first bit stream into
// W-bit words presented on a valid/ready output.
//   clk, rst              : clock, synchronous active-high reset
//   sync                  : frame-align, drops the partial word, idx -> 0
//   bit_in, bit_valid     : serial input
//   bit_ready             : a bit can be accepted this cycle
//   idx                   : position the next accepted bit is written to
//   dout, dout_valid      : assembled word and its valid flag
//   dout_ready            : consumer takes dout this cycle
module demux32_sipo import demux32_pkg::*; #(
  parameter int unsigned W  = demux32_pkg::W,
  parameter int unsigned IW = demux32_pkg::IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam logic [IW-1:0] LAST = IW'(W - 1);

  logic         accept;
  logic         wrap;
  logic [W-1:0] acc;
  logic [W-1:0] acc_next;

  // Only the final bit of a word can stall: it needs a free output slot,
  // or one being emptied in the same cycle.
  assign bit_ready = !rst && !sync && !(idx == LAST && dout_valid && !dout_ready);
  assign accept    = bit_valid && bit_ready;

  bit_index_counter #(
    .IW   (IW),
    .LAST (LAST)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (sync),
    .inc  (accept),
    .idx  (idx),
    .wrap (wrap)
  );

  always_comb begin
    acc_next = acc;
    if (accept) begin
      acc_next[idx] = bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // On completion acc_next equals {bit_in, acc[W-2:0]}.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (wrap) begin
      dout       <= acc_next;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux32_sipo.sv
module tb_demux32_sipo;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  logic          clk;
  logic          rst;
  logic          sync;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [IW-1:0] idx;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  demux32_sipo #(
    .W  (W),
    .IW (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .idx        (idx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dout=%h, required no word", dout);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL sb_word: got dout=%h, required %h", dout, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one bit (inputs set at posedge+2) and returns after the edge that accepts it.
  task automatic send_bit(input logic b);
    int unsigned n;
    n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    while (!bit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: got bit_ready=%b, required 1 (idx=%0d)", bit_ready, idx);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int unsigned s = 0; s < W; s++) begin
      send_bit(w[s]);
    end
  endtask

  task automatic drain();
    bit_valid  = 1'b0;
    dout_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; sync = 1'b0; bit_in = 1'b1; bit_valid = 1'b1; dout_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bit_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_bit_ready: got %b, required 0", bit_ready);
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (idx !== '0 || dout !== '0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got idx=%0d dout=%h dout_valid=%b, required 0 0 0", idx, dout, dout_valid);
    end
    rst = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_bit_ready: got %b, required 1", bit_ready);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_round_trip();
    int c0;
    dout_ready = 1'b1;
    c0 = cyc;
    exp_q.push_back(32'hCCCCCCCC);
    send_word(32'hCCCCCCCC);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'hCCCCCCCC) begin
      errors++;
      $display("FAIL rt_first: got dout=%h valid=%b, required CCCCCCCC 1", dout, dout_valid);
    end
    exp_q.push_back(32'h0CCCCCCC);
    send_word(32'h0CCCCCCC);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h0CCCCCCC) begin
      errors++;
      $display("FAIL rt_second: got dout=%h valid=%b, required 0CCCCCCC 1", dout, dout_valid);
    end
    checks++;
    if (cyc - c0 != 64) begin
      errors++;
      $display("FAIL rt_throughput: got %0d cycles, required 64", cyc - c0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0;
    exp_q.push_back(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5);
    for (int unsigned s = 0; s < W - 1; s++) begin
      checks++;
      if (idx !== IW'(s)) begin
        errors++;
        $display("FAIL bp_idx: got %0d, required %0d", idx, s);
      end
      send_bit(1'b1);
    end
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bit_ready !== 1'b0 || idx !== IW'(W - 1) || dout !== 32'hA5A5A5A5 || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall: got ready=%b idx=%0d dout=%h valid=%b, required 0 31 A5A5A5A5 1",
                 bit_ready, idx, dout, dout_valid);
      end
    end
    @(posedge clk);
    #2;
    exp_q.push_back(32'hFFFFFFFF);
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, required 1", bit_ready);
    end
    @(posedge clk);
    #2;
    checks++;
    if (dout !== 32'hFFFFFFFF || dout_valid !== 1'b1 || idx !== '0) begin
      errors++;
      $display("FAIL bp_release: got dout=%h valid=%b idx=%0d, required FFFFFFFF 1 0", dout, dout_valid, idx);
    end
    drain();
  endtask

  task automatic test_sync();
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'($urandom_range(0, 1)));
    end
    sync      = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL sync_bit_ready: got %b, required 0", bit_ready);
    end
    @(posedge clk);
    #2;
    sync = 1'b0;
    checks++;
    if (idx !== '0) begin
      errors++;
      $display("FAIL sync_idx: got %0d, required 0", idx);
    end
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678);
    checks++;
    if (dout !== 32'h12345678 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL sync_word: got dout=%h valid=%b, required 12345678 1", dout, dout_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid_word();
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (idx !== '0) begin
      errors++;
      $display("FAIL rstmid_idx: got %0d, required 0", idx);
    end
    exp_q.push_back(32'h00000001);
    send_word(32'h00000001);
    checks++;
    if (dout !== 32'h00000001) begin
      errors++;
      $display("FAIL rstmid_word: got dout=%h, required 00000001", dout);
    end
    drain();
  endtask

  task automatic test_gaps();
    logic [W-1:0] w;
    int unsigned gap;
    w = 32'hDEADBEEF;
    dout_ready = 1'b1;
    exp_q.push_back(w);
    for (int unsigned s = 0; s < W; s++) begin
      gap = $urandom_range(0, 2);
      bit_valid = 1'b0;
      for (int unsigned g = 0; g < gap; g++) begin
        step();
      end
      checks++;
      if (idx !== IW'(s)) begin
        errors++;
        $display("FAIL gap_idx: got %0d, required %0d", idx, s);
      end
      send_bit(w[s]);
    end
    checks++;
    if (dout !== 32'hDEADBEEF || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_word: got dout=%h valid=%b, required DEADBEEF 1", dout, dout_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_backpressure();
    test_sync();
    test_reset_mid_word();
    test_gaps();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending words, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
